csr_regfile: RTL

- Machine-mode Control & Status Register file for the RV32IM pipeline.
- It is the responder side of the CSR access path. It answers combinational read requests from the CSR functional unit in EXE and previews WARL-masked next values for forwarding.
- It commits CSR writes in the WB stage, runs the cycle/instret counters, and captures trap and MRET state updates.

---
 rtl/cpu_params_pkg.sv | 41 ++++
 rtl/cpu_structs_pkg.sv | 13 +
 rtl/csr_counter64.sv | 22 ++
 rtl/csr_regfile.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/cpu_params_pkg.sv
// Shared CPU constants: CSR addresses, WARL write masks and mstatus/mip bit positions.
// latency: n/a; backpressure: n/a
package cpu_params_pkg;
  localparam int RSZ = 32;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam logic [RSZ-1:0] MSTATUS_WMASK = 32'h0000_0088;
  localparam logic [RSZ-1:0] MIE_WMASK     = 32'h0000_0888;
  localparam logic [RSZ-1:0] MTVEC_WMASK   = 32'hFFFF_FFFD;
  localparam logic [RSZ-1:0] MEPC_WMASK    = 32'hFFFF_FFFC;
  localparam logic [RSZ-1:0] FULL_WMASK    = 32'hFFFF_FFFF;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LSB  = 11;

  localparam int MIP_MSIP_BIT = 3;
  localparam int MIP_MTIP_BIT = 7;
  localparam int MIP_MEIP_BIT = 11;
endpackage

// File: rtl/cpu_structs_pkg.sv
// Packed register layouts shared across the pipeline.
// latency: n/a; backpressure: n/a
package cpu_structs_pkg;
  typedef struct packed {
    logic [18:0] rsvd_hi;
    logic [1:0]  mpp;
    logic [2:0]  rsvd_mid;
    logic        mpie;
    logic [2:0]  rsvd_lo;
    logic        mie;
    logic [2:0]  rsvd_0;
  } mstatus_t;
endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with per-half overwrite; a write cycle holds off the increment (no carry).
// latency: 1 cycle to update; backpressure: none
module csr_counter64 (
  input  logic        clk,
  input  logic        reset,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wr_data,
  output logic [63:0] count
);
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (wr_lo || wr_hi) begin
      if (wr_lo) count[31:0]  <= wr_data;
      if (wr_hi) count[63:32] <= wr_data;
    end else if (inc) begin
      count <= count + 64'd1;
    end
  end
endmodule

// File: rtl/csr_regfile.sv
// Machine-mode CSR file: combinational reads/WARL preview, WB commit, counters, trap/MRET state.
// latency: reads 0 cycles, writes visible next cycle; backpressure: none, always accepts
module csr_regfile
  import cpu_params_pkg::*;
  import cpu_structs_pkg::*;
#(
  parameter logic [RSZ-1:0] MISA_VAL  = 32'h4000_1100,
  parameter logic [RSZ-1:0] HART_ID   = 32'd0,
  parameter logic [RSZ-1:0] MTVEC_RST = 32'h0000_0000
) (
  input  logic           clk_in,
  input  logic           reset_in,
  input  logic [11:0]    csr_rd_addr,
  output logic [RSZ-1:0] csr_rd_data,
  output logic           csr_avail,
  input  logic [11:0]    nxt_csr_wr_addr,
  input  logic [RSZ-1:0] nxt_csr_wr_data,
  output logic [RSZ-1:0] nxt_csr_rd_data,
  input  logic           wb_csr_wr,
  input  logic [11:0]    wb_csr_wr_addr,
  input  logic [RSZ-1:0] wb_csr_wr_data,
  input  logic           retire_in,
  input  logic           trap_in,
  input  logic [RSZ-1:0] trap_cause,
  input  logic [RSZ-1:0] trap_pc,
  input  logic [RSZ-1:0] trap_tval,
  input  logic           mret_in,
  input  logic           ext_irq,
  input  logic           timer_irq,
  input  logic           sw_irq,
  output logic [RSZ-1:0] mtvec_out,
  output logic [RSZ-1:0] mepc_out,
  output logic           mstatus_mie,
  output logic           irq_pending
);
  logic           mst_mie, mst_mpie;
  logic [RSZ-1:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [RSZ-1:0] mip, wb_val;
  logic [63:0]    mcycle, minstret;
  mstatus_t       mstatus;

  always_comb begin
    mstatus      = '0;
    mstatus.mpp  = 2'b11;
    mstatus.mpie = mst_mpie;
    mstatus.mie  = mst_mie;
    mip               = '0;
    mip[MIP_MSIP_BIT] = sw_irq;
    mip[MIP_MTIP_BIT] = timer_irq;
    mip[MIP_MEIP_BIT] = ext_irq;
  end

  function automatic logic [RSZ-1:0] csr_read(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:                           csr_read = mstatus;
      CSR_MISA:                              csr_read = MISA_VAL;
      CSR_MIE:                               csr_read = mie_q;
      CSR_MTVEC:                             csr_read = mtvec_q;
      CSR_MSCRATCH:                          csr_read = mscratch_q;
      CSR_MEPC:                              csr_read = mepc_q;
      CSR_MCAUSE:                            csr_read = mcause_q;
      CSR_MTVAL:                             csr_read = mtval_q;
      CSR_MIP:                               csr_read = mip;
      CSR_MCYCLE, CSR_CYCLE:                 csr_read = mcycle[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:               csr_read = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:             csr_read = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH:           csr_read = minstret[63:32];
      CSR_MHARTID:                           csr_read = HART_ID;
      default:                               csr_read = '0;
    endcase
  endfunction

  function automatic logic csr_impl(input logic [11:0] a);
    case (a)
      CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
      CSR_MTVAL, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET, CSR_MINSTRETH,
      CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET, CSR_INSTRETH, CSR_MVENDORID, CSR_MARCHID,
      CSR_MIMPID, CSR_MHARTID:               csr_impl = 1'b1;
      default:                               csr_impl = 1'b0;
    endcase
  endfunction

  // Zero mask means the address ignores writes, so the merge returns the current value.
  function automatic logic [RSZ-1:0] csr_wmask(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:                           csr_wmask = MSTATUS_WMASK;
      CSR_MIE:                               csr_wmask = MIE_WMASK;
      CSR_MTVEC:                             csr_wmask = MTVEC_WMASK;
      CSR_MEPC:                              csr_wmask = MEPC_WMASK;
      CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL,
      CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
      CSR_MINSTRETH:                         csr_wmask = FULL_WMASK;
      default:                               csr_wmask = '0;
    endcase
  endfunction

  always_comb begin
    csr_rd_data     = csr_read(csr_rd_addr);
    csr_avail       = csr_impl(csr_rd_addr);
    nxt_csr_rd_data = (csr_read(nxt_csr_wr_addr) & ~csr_wmask(nxt_csr_wr_addr))
                    | (nxt_csr_wr_data & csr_wmask(nxt_csr_wr_addr));
    wb_val          = (csr_read(wb_csr_wr_addr) & ~csr_wmask(wb_csr_wr_addr))
                    | (wb_csr_wr_data & csr_wmask(wb_csr_wr_addr));
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RST;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else begin
      if (wb_csr_wr) begin
        case (wb_csr_wr_addr)
          CSR_MIE:      mie_q      <= wb_val;
          CSR_MTVEC:    mtvec_q    <= wb_val;
          CSR_MSCRATCH: mscratch_q <= wb_val;
          default: ;
        endcase
      end
      // A trap owns mstatus/mepc/mcause/mtval this edge; MRET owns only mstatus.
      if (trap_in) begin
        mepc_q   <= trap_pc & MEPC_WMASK;
        mcause_q <= trap_cause;
        mtval_q  <= trap_tval;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
      end else begin
        if (mret_in) begin
          mst_mie  <= mst_mpie;
          mst_mpie <= 1'b1;
        end else if (wb_csr_wr && wb_csr_wr_addr == CSR_MSTATUS) begin
          mst_mie  <= wb_val[MSTATUS_MIE_BIT];
          mst_mpie <= wb_val[MSTATUS_MPIE_BIT];
        end
        if (wb_csr_wr) begin
          case (wb_csr_wr_addr)
            CSR_MEPC:   mepc_q   <= wb_val;
            CSR_MCAUSE: mcause_q <= wb_val;
            CSR_MTVAL:  mtval_q  <= wb_val;
            default: ;
          endcase
        end
      end
    end
  end

  csr_counter64 u_mcycle (
    .clk     (clk_in),
    .reset   (reset_in),
    .inc     (1'b1),
    .wr_lo   (wb_csr_wr && wb_csr_wr_addr == CSR_MCYCLE),
    .wr_hi   (wb_csr_wr && wb_csr_wr_addr == CSR_MCYCLEH),
    .wr_data (wb_csr_wr_data),
    .count   (mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk_in),
    .reset   (reset_in),
    .inc     (retire_in),
    .wr_lo   (wb_csr_wr && wb_csr_wr_addr == CSR_MINSTRET),
    .wr_hi   (wb_csr_wr && wb_csr_wr_addr == CSR_MINSTRETH),
    .wr_data (wb_csr_wr_data),
    .count   (minstret)
  );

  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign mstatus_mie = mst_mie;
  assign irq_pending = (|(mip & mie_q)) & mst_mie;
endmodule
